// File: rtl/custom_instruction_pkg.sv
// Shared types and widths for the custom-instruction hub.
// Holds the default bus widths, the command bundle type and the index-width helper.
package custom_instruction_pkg;

  localparam int CI_FUNC_ID_W = 10;
  localparam int CI_DATA_W    = 32;

  typedef struct packed {
    logic [CI_FUNC_ID_W-1:0] function_id;
    logic [CI_DATA_W-1:0]    inputs_0;
    logic [CI_DATA_W-1:0]    inputs_1;
  } ci_cmd_t;

  // A single CPU still needs a one-bit index so the tag FIFO never collapses to zero width.
  function automatic int CPU_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ci_tag_fifo.sv
// In-order tag FIFO that remembers which CPU issued each in-flight command.
// First-word-fall-through: head is valid whenever empty is low.
module ci_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Tag storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/custom_instruction_hub.sv
// Shares one custom-instruction accelerator among CPU_COUNT CPU ports.
// Round-robin command arbitration with grant lock; responses routed in order via a tag FIFO.
module custom_instruction_hub
  import custom_instruction_pkg::*;
#(
  parameter int CPU_COUNT       = 4,
  parameter int FUNC_ID_W       = CI_FUNC_ID_W,
  parameter int DATA_W          = CI_DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CPU_COUNT-1:0]                   cpu_cmd_valid,
  output logic [CPU_COUNT-1:0]                   cpu_cmd_ready,
  input  logic [CPU_COUNT*FUNC_ID_W-1:0]         cpu_cmd_function_id,
  input  logic [CPU_COUNT*DATA_W-1:0]            cpu_cmd_inputs_0,
  input  logic [CPU_COUNT*DATA_W-1:0]            cpu_cmd_inputs_1,
  output logic [CPU_COUNT-1:0]                   cpu_rsp_valid,
  input  logic [CPU_COUNT-1:0]                   cpu_rsp_ready,
  output logic [DATA_W-1:0]                      cpu_rsp_outputs_0,
  output logic                                   acc_cmd_valid,
  input  logic                                   acc_cmd_ready,
  output logic [FUNC_ID_W-1:0]                   acc_cmd_function_id,
  output logic [DATA_W-1:0]                      acc_cmd_inputs_0,
  output logic [DATA_W-1:0]                      acc_cmd_inputs_1,
  input  logic                                   acc_rsp_valid,
  output logic                                   acc_rsp_ready,
  input  logic [DATA_W-1:0]                      acc_rsp_outputs_0,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_orphan_rsp
);

  localparam int              IDX_W    = CPU_IDX_W(CPU_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CPU_COUNT - 1);

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] lock_idx_r;
  logic             lock_r;
  logic             err_orphan_r;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] rr_pick_s;
  logic             rr_found_s;
  logic [IDX_W-1:0] grant_s;
  logic             req_s;
  logic [IDX_W-1:0] head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             cmd_fire_s;
  logic             rsp_fire_s;

  // First requester at or after the round-robin pointer.
  always_comb begin
    cand_s     = {IDX_W{1'b0}};
    rr_pick_s  = rr_ptr_r;
    rr_found_s = 1'b0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      cand_s = IDX_W'((int'(rr_ptr_r) + i) % CPU_COUNT);
      if (!rr_found_s && cpu_cmd_valid[cand_s]) begin
        rr_found_s = 1'b1;
        rr_pick_s  = cand_s;
      end else begin
        rr_pick_s  = rr_pick_s;
      end
    end
  end

  // A stalled grant is held so the accelerator sees a stable command.
  assign grant_s    = lock_r ? lock_idx_r : rr_pick_s;
  assign req_s      = lock_r ? cpu_cmd_valid[lock_idx_r] : rr_found_s;
  assign acc_cmd_valid = !reset && !fifo_full_s && req_s;
  assign cmd_fire_s = acc_cmd_valid && acc_cmd_ready;

  assign acc_cmd_function_id = cpu_cmd_function_id[grant_s*FUNC_ID_W +: FUNC_ID_W];
  assign acc_cmd_inputs_0    = cpu_cmd_inputs_0[grant_s*DATA_W +: DATA_W];
  assign acc_cmd_inputs_1    = cpu_cmd_inputs_1[grant_s*DATA_W +: DATA_W];

  // Only the granted CPU sees ready, and only when its command is actually taken.
  always_comb begin
    cpu_cmd_ready = {CPU_COUNT{1'b0}};
    if (cmd_fire_s) begin
      cpu_cmd_ready[grant_s] = 1'b1;
    end else begin
      cpu_cmd_ready = {CPU_COUNT{1'b0}};
    end
  end

  // Route the accelerator result to the CPU at the head of the tag FIFO.
  always_comb begin
    cpu_rsp_valid = {CPU_COUNT{1'b0}};
    acc_rsp_ready = 1'b0;
    if (!reset && !fifo_empty_s) begin
      cpu_rsp_valid[head_s] = acc_rsp_valid;
      acc_rsp_ready         = cpu_rsp_ready[head_s];
    end else begin
      acc_rsp_ready = 1'b0;
    end
  end

  assign rsp_fire_s        = acc_rsp_valid && acc_rsp_ready;
  assign cpu_rsp_outputs_0 = acc_rsp_outputs_0;
  assign err_orphan_rsp    = err_orphan_r;

  ci_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_fire_s),
    .push_data (grant_s),
    .pop       (rsp_fire_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (outstanding)
  );

  // Round-robin pointer, grant lock and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r     <= {IDX_W{1'b0}};
      lock_r       <= 1'b0;
      lock_idx_r   <= {IDX_W{1'b0}};
      err_orphan_r <= 1'b0;
    end else begin
      if (cmd_fire_s) begin
        rr_ptr_r <= (grant_s == LAST_IDX) ? {IDX_W{1'b0}} : grant_s + IDX_W'(1);
        lock_r   <= 1'b0;
      end else if (acc_cmd_valid) begin
        lock_r     <= 1'b1;
        lock_idx_r <= grant_s;
      end else begin
        lock_r <= 1'b0;
      end
      if (fifo_empty_s && acc_rsp_valid) begin
        err_orphan_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_custom_instruction_hub.sv
// Directed bench for custom_instruction_hub: per-cycle vector table plus
// reset, fairness and orphan-response sequences.
module tb_custom_instruction_hub;

  localparam int N  = 4;
  localparam int FW = 10;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int OW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    cpu_cmd_valid;
  logic [N-1:0]    cpu_cmd_ready;
  logic [N*FW-1:0] cpu_cmd_function_id;
  logic [N*DW-1:0] cpu_cmd_inputs_0;
  logic [N*DW-1:0] cpu_cmd_inputs_1;
  logic [N-1:0]    cpu_rsp_valid;
  logic [N-1:0]    cpu_rsp_ready;
  logic [DW-1:0]   cpu_rsp_outputs_0;
  logic            acc_cmd_valid;
  logic            acc_cmd_ready;
  logic [FW-1:0]   acc_cmd_function_id;
  logic [DW-1:0]   acc_cmd_inputs_0;
  logic [DW-1:0]   acc_cmd_inputs_1;
  logic            acc_rsp_valid;
  logic            acc_rsp_ready;
  logic [DW-1:0]   acc_rsp_outputs_0;
  logic [OW-1:0]   outstanding;
  logic            err_orphan_rsp;

  always #5 clk = ~clk;

  custom_instruction_hub #(
    .CPU_COUNT       (N),
    .FUNC_ID_W       (FW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cpu_cmd_valid       (cpu_cmd_valid),
    .cpu_cmd_ready       (cpu_cmd_ready),
    .cpu_cmd_function_id (cpu_cmd_function_id),
    .cpu_cmd_inputs_0    (cpu_cmd_inputs_0),
    .cpu_cmd_inputs_1    (cpu_cmd_inputs_1),
    .cpu_rsp_valid       (cpu_rsp_valid),
    .cpu_rsp_ready       (cpu_rsp_ready),
    .cpu_rsp_outputs_0   (cpu_rsp_outputs_0),
    .acc_cmd_valid       (acc_cmd_valid),
    .acc_cmd_ready       (acc_cmd_ready),
    .acc_cmd_function_id (acc_cmd_function_id),
    .acc_cmd_inputs_0    (acc_cmd_inputs_0),
    .acc_cmd_inputs_1    (acc_cmd_inputs_1),
    .acc_rsp_valid       (acc_rsp_valid),
    .acc_rsp_ready       (acc_rsp_ready),
    .acc_rsp_outputs_0   (acc_rsp_outputs_0),
    .outstanding         (outstanding),
    .err_orphan_rsp      (err_orphan_rsp)
  );

  typedef struct {
    logic [3:0]  cv;
    logic        ar;
    logic        rv;
    logic [3:0]  rr;
    logic [31:0] rdata;
    logic [3:0]  e_cready;
    logic        e_avalid;
    logic [1:0]  e_g;
    logic [3:0]  e_rvalid;
    logic        e_arready;
    logic [2:0]  e_out;
  } vec_t;

  vec_t        vecs [24];
  logic [9:0]  fid_tab [4] = '{10'h010, 10'h011, 10'h005, 10'h013};
  logic [31:0] in0_tab [4] = '{32'h000000A0, 32'h000000A1, 32'h00000011, 32'h000000A3};
  logic [31:0] in1_tab [4] = '{32'h000000B0, 32'h000000B1, 32'h00000022, 32'h000000B3};

  int n_checks = 0;
  int n_fail   = 0;
  int grants [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // cv, ar, rv, rr, rdata, e_cready, e_avalid, e_g, e_rvalid, e_arready, e_out
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 3'd0};
    vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 3'd1};
    vecs[2]  = '{4'b0000, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 3'd1};
    vecs[3]  = '{4'b0000, 1'b1, 1'b1, 4'b1111, 32'h33, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 3'd1};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 3'd0};
    vecs[5]  = '{4'b0010, 1'b0, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[6]  = '{4'b0011, 1'b0, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[7]  = '{4'b0011, 1'b0, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[9]  = '{4'b0011, 1'b0, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[10] = '{4'b0011, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[11] = '{4'b0001, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 3'd1};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 4'b1101, 32'h44, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 3'd2};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 32'h44, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 3'd2};
    vecs[14] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 32'h45, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 3'd1};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 3'd0};
    vecs[16] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 3'd0};
    vecs[17] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 3'd1};
    vecs[18] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 3'd2};
    vecs[19] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 3'd3};
    vecs[20] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 3'd4};
    vecs[21] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 32'h55, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 3'd4};
    vecs[22] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 32'h66, 4'b0010, 1'b1, 2'd1, 4'b0100, 1'b1, 3'd3};
    vecs[23] = '{4'b0000, 1'b1, 1'b0, 4'b1111, 32'h00, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 3'd3};

    for (int i = 0; i < N; i++) begin
      cpu_cmd_function_id[i*FW +: FW] = fid_tab[i];
      cpu_cmd_inputs_0[i*DW +: DW]    = in0_tab[i];
      cpu_cmd_inputs_1[i*DW +: DW]    = in1_tab[i];
      grants[i] = 0;
    end

    // Reset with every CPU requesting: hub outputs must stay quiet.
    reset = 1'b1;
    cpu_cmd_valid = 4'b1111;
    cpu_rsp_ready = 4'b1111;
    acc_cmd_ready = 1'b1;
    acc_rsp_valid = 1'b0;
    acc_rsp_outputs_0 = 32'h0;
    @(negedge clk);
    check("reset acc_cmd_valid", 64'(acc_cmd_valid), 64'd0);
    check("reset cpu_cmd_ready", 64'(cpu_cmd_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_cmd_valid = 4'b0000;
    @(negedge clk);
    check("post-reset outstanding", 64'(outstanding), 64'd0);
    check("post-reset err_orphan", 64'(err_orphan_rsp), 64'd0);
    check("post-reset acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
    check("post-reset cpu_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Single command, lock under stall, response backpressure, full FIFO.
    for (int r = 0; r < 24; r++) begin
      cpu_cmd_valid     = vecs[r].cv;
      acc_cmd_ready     = vecs[r].ar;
      acc_rsp_valid     = vecs[r].rv;
      cpu_rsp_ready     = vecs[r].rr;
      acc_rsp_outputs_0 = vecs[r].rdata;
      @(negedge clk);
      check($sformatf("row%0d cpu_cmd_ready", r), 64'(cpu_cmd_ready), 64'(vecs[r].e_cready));
      check($sformatf("row%0d acc_cmd_valid", r), 64'(acc_cmd_valid), 64'(vecs[r].e_avalid));
      if (vecs[r].e_avalid) begin
        check($sformatf("row%0d function_id", r), 64'(acc_cmd_function_id), 64'(fid_tab[vecs[r].e_g]));
        check($sformatf("row%0d inputs_0", r), 64'(acc_cmd_inputs_0), 64'(in0_tab[vecs[r].e_g]));
        check($sformatf("row%0d inputs_1", r), 64'(acc_cmd_inputs_1), 64'(in1_tab[vecs[r].e_g]));
      end
      check($sformatf("row%0d cpu_rsp_valid", r), 64'(cpu_rsp_valid), 64'(vecs[r].e_rvalid));
      if (vecs[r].e_rvalid != 4'b0000) begin
        check($sformatf("row%0d rsp data", r), 64'(cpu_rsp_outputs_0), 64'(vecs[r].rdata));
      end
      check($sformatf("row%0d acc_rsp_ready", r), 64'(acc_rsp_ready), 64'(vecs[r].e_arready));
      check($sformatf("row%0d outstanding", r), 64'(outstanding), 64'(vecs[r].e_out));
      check($sformatf("row%0d err_orphan", r), 64'(err_orphan_rsp), 64'd0);
      @(posedge clk); #1;
    end

    // Reset with three commands in flight.
    reset = 1'b1;
    cpu_cmd_valid = 4'b1111;
    acc_rsp_valid = 1'b1;
    @(negedge clk);
    check("midreset acc_cmd_valid", 64'(acc_cmd_valid), 64'd0);
    check("midreset cpu_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    check("midreset acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_cmd_valid = 4'b0000;
    acc_rsp_valid = 1'b0;
    @(negedge clk);
    check("midreset outstanding", 64'(outstanding), 64'd0);
    check("midreset err_orphan", 64'(err_orphan_rsp), 64'd0);
    check("midreset acc_rsp_ready after", 64'(acc_rsp_ready), 64'd0);
    @(posedge clk); #1;

    // Fairness: all CPUs request, single-cycle accelerator answers the next cycle.
    cpu_cmd_valid = 4'b1111;
    acc_cmd_ready = 1'b1;
    cpu_rsp_ready = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      int g;
      acc_rsp_valid     = (k > 0);
      acc_rsp_outputs_0 = 32'(k);
      @(negedge clk);
      g = -1;
      for (int j = 0; j < N; j++) begin
        if (cpu_cmd_ready[j]) g = j;
      end
      check($sformatf("fair grant %0d", k), 64'(g), 64'(k % 4));
      if (g >= 0) grants[g]++;
      if (k > 0) begin
        check($sformatf("fair rsp_valid %0d", k), 64'(cpu_rsp_valid), 64'(4'b0001 << ((k - 1) % 4)));
        check($sformatf("fair outstanding %0d", k), 64'(outstanding), 64'd1);
      end
      @(posedge clk); #1;
    end
    for (int j = 0; j < N; j++) begin
      check($sformatf("fair count cpu%0d", j), 64'(grants[j]), 64'd10);
    end
    cpu_cmd_valid = 4'b0000;
    acc_rsp_valid = 1'b1;
    @(negedge clk);
    check("fair drain rsp_valid", 64'(cpu_rsp_valid), 64'(4'b1000));
    @(posedge clk); #1;
    acc_rsp_valid = 1'b0;
    @(negedge clk);
    check("fair drain outstanding", 64'(outstanding), 64'd0);
    @(posedge clk); #1;

    // Orphan response with an empty FIFO sets a sticky error.
    acc_rsp_valid = 1'b1;
    @(negedge clk);
    check("orphan acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
    check("orphan cpu_rsp_valid", 64'(cpu_rsp_valid), 64'd0);
    check("orphan err before", 64'(err_orphan_rsp), 64'd0);
    @(posedge clk); #1;
    acc_rsp_valid = 1'b0;
    @(negedge clk);
    check("orphan err set", 64'(err_orphan_rsp), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("orphan err sticky", 64'(err_orphan_rsp), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("orphan err cleared", 64'(err_orphan_rsp), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
